raf_byte_fifo: RTL

Synchronous byte FIFO that sits directly upstream of the RaF read-and-fetch stage and buffers the incoming byte stream. It supplies RaF's `q`, `empty` and `rdreq` interface. It uses normal (non-show-ahead) read timing: `q` updates one clock after an accepted read. The write side is driven by the byte producer, which uses `full`/`almost_full` for back-pressure; sticky error flags record protocol violations on either side.

---
 rtl/raf_byte_fifo.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/raf_byte_fifo.sv
// Byte FIFO feeding the RaF read-and-fetch stage. It uses normal-mode reads, so q is registered
// and updates one clock after an accepted rdreq. Sticky ovf/udf flags record rejected accesses.

module raf_byte_fifo_ctl #(
    parameter int DEPTH    = 16,
    parameter int AW       = $clog2(DEPTH),
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          sclr,
    input  logic          wrreq,
    input  logic          rdreq,
    output logic          wr_en,
    output logic          rd_en,
    output logic [AW-1:0] wr_ptr,
    output logic [AW-1:0] rd_ptr,
    output logic [AW:0]   usedw,
    output logic          empty,
    output logic          full,
    output logic          almost_full,
    output logic          ovf,
    output logic          udf
);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_W    = (AW+1)'(AF_LEVEL);

    logic [AW:0] usedw_nxt;

    // Status flags decode from the registered count only, so no input reaches them combinationally.
    assign empty       = (usedw == '0);
    assign full        = (usedw == DEPTH_W);
    assign almost_full = (usedw >= AF_W);

    assign wr_en = wrreq && !full  && !sclr;
    assign rd_en = rdreq && !empty && !sclr;

    always_comb begin
        usedw_nxt = usedw;
        case ({wr_en, rd_en})
            2'b10:   usedw_nxt = usedw + 1'b1;
            2'b01:   usedw_nxt = usedw - 1'b1;
            default: usedw_nxt = usedw;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            usedw  <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else if (sclr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            usedw  <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            usedw <= usedw_nxt;
            if (wrreq && full)  ovf <= 1'b1;
            if (rdreq && empty) udf <= 1'b1;
        end
    end
endmodule

module raf_byte_fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             sclr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_ptr,
    input  logic [WIDTH-1:0] data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_ptr,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] mem [DEPTH];

    // The storage array has no reset. Stale entries are never visible because the pointers are reset.
    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_ptr] <= data;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)      q <= '0;
        else if (sclr)  q <= '0;
        else if (rd_en) q <= mem[rd_ptr];
    end
endmodule

module raf_byte_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AW       = $clog2(DEPTH),
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             sclr,
    input  logic             wrreq,
    input  logic [WIDTH-1:0] data,
    input  logic             rdreq,
    output logic [WIDTH-1:0] q,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic [AW:0]      usedw,
    output logic             ovf,
    output logic             udf
);
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    raf_byte_fifo_ctl #(.DEPTH(DEPTH), .AW(AW), .AF_LEVEL(AF_LEVEL)) u_ctl (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .sclr        (sclr),
        .wrreq       (wrreq),
        .rdreq       (rdreq),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .wr_ptr      (wr_ptr),
        .rd_ptr      (rd_ptr),
        .usedw       (usedw),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .ovf         (ovf),
        .udf         (udf)
    );

    raf_byte_fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .sclr   (sclr),
        .wr_en  (wr_en),
        .wr_ptr (wr_ptr),
        .data   (data),
        .rd_en  (rd_en),
        .rd_ptr (rd_ptr),
        .q      (q)
    );
endmodule
